// File: rtl/pll_ctrl_pkg.sv
// Shared types and sizing helpers for the PLL lock supervisor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: sequencer state enum, counter-width helper.
package pll_ctrl_pkg;

   typedef enum logic [2:0] {
      RESET     = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      RUN       = 3'd3,
      FAULT     = 3'd4
   } state_e;

   // One counter serves every timed state, so it must hold the largest
   // terminal count of the three.
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// Bundle of PLL control / status signals between supervisor and PLL/system side.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are level or single-cycle pulses.
//
// master: the supervisor (consumes pll_lock/restart, drives the rest).
// slave : the PLL / system side.
interface pll_lock_supervisor_if;
   logic       pll_lock;   // raw PLL LOCK, asynchronous to clk_in
   logic       restart;    // single-cycle request for a new attempt
   logic       pll_reset;  // PLL RESET, active-high
   logic       sys_rst_n;  // downstream reset, active-low
   logic       ready;      // high only in RUN
   logic       fault;      // high only in FAULT
   logic [3:0] retry_cnt;  // failed attempts in current sequence
   logic [7:0] loss_cnt;   // lock losses seen in RUN, saturating

   modport master (
      input  pll_lock, restart,
      output pll_reset, sys_rst_n, ready, fault, retry_cnt, loss_cnt
   );

   modport slave (
      output pll_lock, restart,
      input  pll_reset, sys_rst_n, ready, fault, retry_cnt, loss_cnt
   );
endinterface

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous level.
// Latency: input visible on q after 2 clk edges.
// Backpressure: none.
//
// Ports: clk, rst_n (async active-low, resets to 0), d (async in), q (synced out).
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, lock wait and lock qualification; gates downstream reset; retries then faults.
// Latency: lock sampled at E0 -> RUN at E(2+STABLE_CYCLES); lock loss in RUN -> reset at E2.
// Backpressure: none; restart is accepted in any state and wins over every other transition.
//
// Ports: clk_in (PLL reference clock), rst_n (async active-low), bus (master modport:
// pll_lock/restart in; pll_reset, sys_rst_n, ready, fault, retry_cnt, loss_cnt out).
module pll_lock_supervisor
   import pll_ctrl_pkg::*;
#(
   parameter int RESET_PULSE   = 16,
   parameter int LOCK_TIMEOUT  = 27000,
   parameter int STABLE_CYCLES = 2700,
   parameter int MAX_RETRIES   = 3
) (
   input  logic                  clk_in,
   input  logic                  rst_n,
   pll_lock_supervisor_if.master bus
);

   localparam int CNT_W = cnt_width(RESET_PULSE, LOCK_TIMEOUT, STABLE_CYCLES);

   localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(RESET_PULSE - 1);
   localparam logic [CNT_W-1:0] LT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] SC_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRIES);

   state_e           st, st_nxt;
   logic [CNT_W-1:0] cnt;
   logic [3:0]       retry_nxt;
   logic [7:0]       loss_nxt;
   logic             lock_s;
   logic             fail;

   sync_2ff u_lock_sync (
      .clk   (clk_in),
      .rst_n (rst_n),
      .d     (bus.pll_lock),
      .q     (lock_s)
   );

   always_comb begin
      st_nxt    = st;
      retry_nxt = bus.retry_cnt;
      loss_nxt  = bus.loss_cnt;
      fail      = 1'b0;

      if (bus.restart) begin
         st_nxt    = RESET;
         retry_nxt = 4'd0;
      end else begin
         case (st)
            RESET: begin
               if (cnt == RP_LAST) st_nxt = WAIT_LOCK;
            end
            WAIT_LOCK: begin
               if (lock_s)                st_nxt = STABLE;
               else if (cnt == LT_LAST)   fail   = 1'b1;
            end
            STABLE: begin
               // Any dropout while qualifying counts as a failed attempt.
               if (!lock_s) begin
                  fail = 1'b1;
               end else if (cnt == SC_LAST) begin
                  st_nxt    = RUN;
                  retry_nxt = 4'd0;
               end
            end
            RUN: begin
               if (!lock_s) begin
                  st_nxt = RESET;
                  if (bus.loss_cnt != 8'hFF) loss_nxt = bus.loss_cnt + 8'd1;
               end
            end
            FAULT:   st_nxt = FAULT;
            default: st_nxt = RESET;
         endcase
      end

      if (fail) begin
         if (bus.retry_cnt == RETRY_MAX) begin
            st_nxt = FAULT;
         end else begin
            retry_nxt = bus.retry_cnt + 4'd1;
            st_nxt    = RESET;
         end
      end
   end

   // Outputs are decoded from the next state so they change on the same
   // edge as the state register and come straight from flops.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         st            <= RESET;
         cnt           <= '0;
         bus.pll_reset <= 1'b1;
         bus.sys_rst_n <= 1'b0;
         bus.ready     <= 1'b0;
         bus.fault     <= 1'b0;
         bus.retry_cnt <= 4'd0;
         bus.loss_cnt  <= 8'd0;
      end else begin
         st <= st_nxt;
         // restart in RESET is not a state change but still starts a full pulse.
         if (bus.restart || (st_nxt != st))
            cnt <= '0;
         else if (st == RESET || st == WAIT_LOCK || st == STABLE)
            cnt <= cnt + CNT_W'(1);
         bus.pll_reset <= (st_nxt == RESET) || (st_nxt == FAULT);
         bus.sys_rst_n <= (st_nxt == RUN);
         bus.ready     <= (st_nxt == RUN);
         bus.fault     <= (st_nxt == FAULT);
         bus.retry_cnt <= retry_nxt;
         bus.loss_cnt  <= loss_nxt;
      end
   end

endmodule
